uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
Receive-side buffer directly downstream of the UART serial receiver.
- Captures each parallel word the receiver presents with its one-cycle done pulse.
- Stores words in a circular buffer and presents them to the CPU/bus side in first-word-fall-through order.
- Its full flag drives the receiver's FIFO-full input, so a full buffer stops new frames from starting.
- Reports fill level, almost-full and a sticky overflow flag.

Parameters:
SIZE_DATA, 16, width of each stored word; matches the receiver's parallel data width.
DEPTH, 16, number of entries; power of two, minimum 2.
AFULL_THRESH, 14, o_afull asserts when level >= this value; legal range 1..DEPTH.

Ports:
i_clk  input  1  clock, shared with the receiver.
i_rst_n  input  1  asynchronous, active-low reset.
i_wr_data  input  SIZE_DATA  word from the receiver's parallel data output.
i_wr_en  input  1  write strobe; connect to the receiver's one-cycle done pulse.
i_rd_en  input  1  pop request from the consumer.
i_clr_ovf  input  1  clears the sticky overflow flag.
o_rd_data  output  SIZE_DATA  head-of-queue word; 0 when empty.
o_rd_valid  output  1  equals ~o_empty.
o_full  output  1  level == DEPTH; connect to the receiver's FIFO-full input.
o_empty  output  1  level == 0.
o_afull  output  1  level >= AFULL_THRESH.
o_level  output  $clog2(DEPTH)+1  current number of stored words.
o_overflow  output  1  sticky: a write was attempted while full.

Behaviour:
- Reset (asynchronous, any time including mid-operation):
  - wr_ptr = rd_ptr = 0, o_level = 0, o_empty = 1, o_full = 0, o_afull = 0, o_overflow = 0, o_rd_data = 0.
  - Storage array is not reset; contents are don't-care.
- Pointers are $clog2(DEPTH)+1 bits and wrap naturally.
  - full = MSBs differ and lower bits equal.
  - empty = pointers equal.
  - o_level = wr_ptr - rd_ptr, modulo 2^(width).
- All status outputs come from registered state and update on the clock edge that changes the pointers. There is no combinational path from i_wr_en or i_rd_en to any status output.
- Write accepted = i_wr_en & ~o_full. The word is stored at wr_ptr and wr_ptr increments.
  - Write to an empty FIFO: o_empty deasserts and o_rd_data shows the word one cycle after the write edge.
- Read accepted = i_rd_en & ~o_empty. rd_ptr increments and the next word appears on o_rd_data in the following cycle.
- o_rd_data = mem[rd_ptr] when non-empty, else 0. Combinational read of the registered array.
- Boundary cases:
  - Write while full and no read: word dropped, pointers unchanged, o_overflow set.
  - Read while empty: ignored, no pointer change, no error flag.
  - Write and read in the same cycle, neither full nor empty: both accepted, level unchanged.
  - Write and read while full: both accepted (the pop frees the slot), level stays DEPTH, o_overflow not set.
  - Write and read while empty: write accepted, read ignored (no bypass), level becomes 1.
  - i_clr_ovf and a new overflow in the same cycle: set wins, o_overflow stays 1.
- Upstream coupling: o_full is registered and is consumed by the receiver only at start-bit detection.
  - A frame already in progress when o_full rises still completes.
  - Its word is dropped and flagged in o_overflow.

Decomposition:
- Shared package uart_pkg:
  - SIZE_DATA default.
  - Function computing pointer width from DEPTH.
  - Typedef for the data word, shared with the receiver and transmitter.
- One natural sub-module, uart_fifo_ram: DEPTH x SIZE_DATA register array with one synchronous write port and one asynchronous read port.
- Pointer, flag and overflow logic stay in uart_rx_fifo.

Test Plan:
- Reset, then write 16'hA5A5, 16'h0001, 16'hFFFF on consecutive cycles, then pop 3 times -> o_rd_data reads A5A5, 0001, FFFF in order; o_level goes 1,2,3 then 2,1,0; o_empty returns to 1.
- Fill 16 words (0..15) -> o_afull rises when o_level reaches 14; o_full rises when it reaches 16. A 17th write -> dropped, o_overflow = 1, o_level stays 16, head still 0.
- Full FIFO with simultaneous write 16'h00AA and pop -> o_level stays 16, o_overflow stays 0, the popped word is 0, and 16'h00AA is later read as the last word.
- Empty FIFO with simultaneous write 16'h1234 and pop -> o_level = 1, o_rd_data = 1234 next cycle; a pop while empty has no effect.
- Wrap-around: 40 push/pop pairs with incrementing data -> data order preserved across pointer wrap, no false full/empty.
- Assert i_rst_n low with 5 words stored -> all outputs at reset values immediately (asynchronous); after release, o_empty = 1 and o_level = 0. Separately, i_clr_ovf pulse clears o_overflow, but not in a cycle that also overflows.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared word type, default data width and pointer sizing for the UART blocks
package uart_pkg;
    localparam int SIZE_DATA_DEFAULT = 16;
    typedef logic [SIZE_DATA_DEFAULT-1:0] word_t;
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/uart_fifo_ram.sv
// uart_fifo_ram: DEPTH x SIZE_DATA register array, synchronous write, asynchronous read
module uart_fifo_ram #(
    parameter int DEPTH     = 16,
    parameter int SIZE_DATA = 16
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [SIZE_DATA-1:0]     wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [SIZE_DATA-1:0]     rd_data
);
    logic [SIZE_DATA-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (wr_en) mem[wr_addr] <= wr_data;

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through receive buffer with registered level/flags and sticky overflow
module uart_rx_fifo import uart_pkg::*; #(
    parameter int SIZE_DATA    = SIZE_DATA_DEFAULT,
    parameter int DEPTH        = 16,
    parameter int AFULL_THRESH = 14
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [SIZE_DATA-1:0]         i_wr_data,
    input  logic                         i_wr_en,
    input  logic                         i_rd_en,
    input  logic                         i_clr_ovf,
    output logic [SIZE_DATA-1:0]         o_rd_data,
    output logic                         o_rd_valid,
    output logic                         o_full,
    output logic                         o_empty,
    output logic                         o_afull,
    output logic [ptr_width(DEPTH)-1:0]  o_level,
    output logic                         o_overflow
);
    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0]        wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, level, level_nxt;
    logic                 full, empty, afull, overflow, wr_ok, rd_ok;
    logic [SIZE_DATA-1:0] head;

    // a pop frees the slot in the same cycle, so a full FIFO still accepts a write paired with a read
    always_comb begin
        rd_ok      = i_rd_en & ~empty;
        wr_ok      = i_wr_en & (~full | i_rd_en);
        wr_ptr_nxt = wr_ptr + PW'(wr_ok);
        rd_ptr_nxt = rd_ptr + PW'(rd_ok);
        level_nxt  = wr_ptr_nxt - rd_ptr_nxt;
    end

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            afull    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            level    <= level_nxt;
            full     <= (wr_ptr_nxt[PW-1] != rd_ptr_nxt[PW-1]) && (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
            empty    <= wr_ptr_nxt == rd_ptr_nxt;
            afull    <= level_nxt >= PW'(AFULL_THRESH);
            overflow <= (i_wr_en & ~wr_ok) | (overflow & ~i_clr_ovf);
        end

    uart_fifo_ram #(.DEPTH(DEPTH), .SIZE_DATA(SIZE_DATA)) u_ram (
        .clk     (i_clk),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (i_wr_data),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (head)
    );

    assign o_rd_data  = empty ? '0 : head;
    assign o_rd_valid = ~empty;
    assign o_full     = full;
    assign o_empty    = empty;
    assign o_afull    = afull;
    assign o_level    = level;
    assign o_overflow = overflow;
endmodule
